// File: rtl/i2c_txn_sched_if.sv
// Bundle between the transaction scheduler, its two requesters and the I2C byte engine.
// Handshake: reqN is held high until the matching done/nack/timeout pulse; gntN stays high for
// the whole owned transaction; m_byte_done is a one-cycle strobe that qualifies m_ack.
interface i2c_txn_sched_if;
   logic       req0, req1;
   logic [6:0] addr0, addr1;
   logic       rw0, rw1;
   logic [3:0] len0, len1;
   logic       gnt0, gnt1;
   logic       m_start, m_stop;
   logic [7:0] m_data;
   logic       m_data_en;
   logic       m_byte_done, m_ack;
   logic       done, nack, timeout;
   logic       busy;

   modport master (
      input  req0, req1, addr0, addr1, rw0, rw1, len0, len1, m_byte_done, m_ack,
      output gnt0, gnt1, m_start, m_stop, m_data, m_data_en, done, nack, timeout, busy
   );

   modport slave (
      output req0, req1, addr0, addr1, rw0, rw1, len0, len1, m_byte_done, m_ack,
      input  gnt0, gnt1, m_start, m_stop, m_data, m_data_en, done, nack, timeout, busy
   );
endinterface

// File: rtl/i2c_txn_sched.sv
// Two-requester round-robin I2C transaction scheduler: start, address byte, data bytes,
// stop, then one status pulse. A watchdog aborts any byte that never completes.
module i2c_txn_sched #(
   parameter int TO_CYC = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   i2c_txn_sched_if.master       bus,
   output logic [2:0]            dbg_state
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      FIN   = 3'd5
   } state_t;

   localparam int WDW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYC - 1);

   state_t         state;
   logic           ptr;
   logic           rw_q;
   logic [3:0]     len_q;
   logic [3:0]     byte_cnt;
   logic [WDW-1:0] wd_cnt;
   logic [1:0]     ph_cnt;
   logic           abort_q;
   logic           to_q;
   logic           pick1;

   // ptr remembers who was served last; on a tie the other requester wins.
   assign pick1     = bus.req1 && (!bus.req0 || !ptr);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= 1'b0;
         rw_q          <= 1'b0;
         len_q         <= 4'd0;
         byte_cnt      <= 4'd0;
         wd_cnt        <= '0;
         ph_cnt        <= 2'd0;
         abort_q       <= 1'b0;
         to_q          <= 1'b0;
         bus.gnt0      <= 1'b0;
         bus.gnt1      <= 1'b0;
         bus.m_start   <= 1'b0;
         bus.m_stop    <= 1'b0;
         bus.m_data    <= 8'd0;
         bus.m_data_en <= 1'b0;
         bus.done      <= 1'b0;
         bus.nack      <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.done    <= 1'b0;
         bus.nack    <= 1'b0;
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state         <= START;
                  bus.gnt0      <= !pick1;
                  bus.gnt1      <= pick1;
                  rw_q          <= pick1 ? bus.rw1 : bus.rw0;
                  len_q         <= pick1 ? bus.len1 : bus.len0;
                  bus.m_data    <= pick1 ? {bus.addr1, bus.rw1} : {bus.addr0, bus.rw0};
                  bus.m_data_en <= 1'b1;
                  bus.m_start   <= 1'b1;
                  bus.busy      <= 1'b1;
                  ph_cnt        <= 2'd0;
                  abort_q       <= 1'b0;
                  to_q          <= 1'b0;
               end
            end
            START: begin
               if (ph_cnt == 2'd3) begin
                  state       <= ADDR;
                  bus.m_start <= 1'b0;
                  wd_cnt      <= '0;
               end else begin
                  ph_cnt <= ph_cnt + 2'd1;
               end
            end
            ADDR: begin
               if (bus.m_byte_done) begin
                  wd_cnt        <= '0;
                  bus.m_data_en <= 1'b0;
                  bus.m_data    <= 8'd0;
                  if (!bus.m_ack || len_q == 4'd0) begin
                     abort_q    <= !bus.m_ack;
                     state      <= STOP;
                     bus.m_stop <= 1'b1;
                     ph_cnt     <= 2'd0;
                  end else begin
                     state    <= DATA;
                     byte_cnt <= len_q;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  to_q          <= 1'b1;
                  bus.m_data_en <= 1'b0;
                  bus.m_data    <= 8'd0;
                  state         <= STOP;
                  bus.m_stop    <= 1'b1;
                  ph_cnt        <= 2'd0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bus.m_byte_done) begin
                  wd_cnt   <= '0;
                  byte_cnt <= byte_cnt - 4'd1;
                  // The master always NACKs the last read byte, so that NACK is not an abort.
                  if (!bus.m_ack && !(rw_q && byte_cnt == 4'd1)) begin
                     abort_q    <= 1'b1;
                     state      <= STOP;
                     bus.m_stop <= 1'b1;
                     ph_cnt     <= 2'd0;
                  end else if (byte_cnt == 4'd1) begin
                     state      <= STOP;
                     bus.m_stop <= 1'b1;
                     ph_cnt     <= 2'd0;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  to_q       <= 1'b1;
                  state      <= STOP;
                  bus.m_stop <= 1'b1;
                  ph_cnt     <= 2'd0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            STOP: begin
               if (ph_cnt == 2'd3) begin
                  state       <= FIN;
                  bus.m_stop  <= 1'b0;
                  bus.timeout <= to_q;
                  bus.nack    <= abort_q && !to_q;
                  bus.done    <= !abort_q && !to_q;
               end else begin
                  ph_cnt <= ph_cnt + 2'd1;
               end
            end
            FIN: begin
               state    <= IDLE;
               ptr      <= bus.gnt1;
               bus.gnt0 <= 1'b0;
               bus.gnt1 <= 1'b0;
               bus.busy <= 1'b0;
               byte_cnt <= 4'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_txn_sched.sv
// Directed bench for i2c_txn_sched: reset, read/write flows, arbitration, NACK,
// watchdog abort and mid-transaction reset, each in its own task.
module tb_i2c_txn_sched;
   localparam int TO = 16;
   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_ADDR = 3'd2,
                          S_DATA = 3'd3, S_STOP = 3'd4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;
   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];

   i2c_txn_sched_if intf();

   i2c_txn_sched #(.TO_CYC(TO)) dut (
      .clk(clk), .reset(reset), .bus(intf.master), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_time_limit: got still running, expected finished");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      intf.req0 = 0; intf.req1 = 0; intf.addr0 = 0; intf.addr1 = 0;
      intf.rw0 = 0; intf.rw1 = 0; intf.len0 = 0; intf.len1 = 0;
      intf.m_byte_done = 0; intf.m_ack = 0;
   endtask

   task automatic apply_reset();
      reset = 1;
      drive_idle();
      repeat (2) tick();
      reset = 0;
      tick();
   endtask

   task automatic pulse_byte(input logic ack);
      intf.m_byte_done = 1; intf.m_ack = ack;
      tick();
      intf.m_byte_done = 0; intf.m_ack = 0;
   endtask

   task automatic wait_state(input logic [2:0] s);
      int n = 0;
      while (dbg_state !== s && n < 64) begin tick(); n++; end
   endtask

   // Counts m_stop-high samples; returns positioned on the first sample after the stop phase.
   task automatic count_stop(output int n);
      int g = 0;
      n = 0;
      while (intf.m_stop !== 1'b1 && g < 64) begin tick(); g++; end
      while (intf.m_stop === 1'b1 && n < 16) begin n++; tick(); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1;
      drive_idle();
      #12;
      tests_run++;
      if ({intf.gnt0, intf.gnt1, intf.busy, intf.m_start, intf.m_stop, intf.m_data_en} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {intf.gnt0, intf.gnt1, intf.busy, intf.m_start, intf.m_stop, intf.m_data_en});
      end
      tests_run++;
      if ({intf.m_data, intf.done, intf.nack, intf.timeout} !== 11'h0) begin
         tests_failed++;
         $display("FAIL reset_data_status: got %h expected 0", {intf.m_data, intf.done, intf.nack, intf.timeout});
      end
      tick();
      reset = 0;
      tick();
      tests_run++;
      if (dbg_state !== S_IDLE || intf.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: got state %0d busy %b expected state 0 busy 0", dbg_state, intf.busy);
      end
   endtask

   task automatic test_read_len2();
      int n;
      exp_q.push_back(8'h95);
      intf.req0 = 1; intf.addr0 = 7'h4A; intf.rw0 = 1; intf.len0 = 4'd2;
      tick();
      tests_run++;
      if ({intf.gnt0, intf.gnt1, intf.m_start, intf.m_data_en} !== 4'b1011) begin
         tests_failed++;
         $display("FAIL rd_grant: got %b expected 1011", {intf.gnt0, intf.gnt1, intf.m_start, intf.m_data_en});
      end
      n = 0;
      while (intf.m_start === 1'b1 && n < 16) begin n++; tick(); end
      tests_run++;
      if (n !== 4) begin
         tests_failed++;
         $display("FAIL rd_start_len: got %0d expected 4", n);
      end
      tests_run++;
      if (dbg_state !== S_ADDR || intf.m_data_en !== 1'b1 || intf.m_data !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL rd_addr_byte: got state %0d en %b data %h expected state 2 en 1 data %h",
                  dbg_state, intf.m_data_en, intf.m_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pulse_byte(1);
      tests_run++;
      if (dbg_state !== S_DATA || intf.m_data_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_data_state: got state %0d en %b expected state 3 en 0", dbg_state, intf.m_data_en);
      end
      tick();
      pulse_byte(1);
      tick();
      pulse_byte(0);
      count_stop(n);
      tests_run++;
      if (n !== 4) begin
         tests_failed++;
         $display("FAIL rd_stop_len: got %0d expected 4", n);
      end
      tests_run++;
      if ({intf.done, intf.nack, intf.timeout, intf.gnt0} !== 4'b1001) begin
         tests_failed++;
         $display("FAIL rd_fin_status: got %b expected 1001", {intf.done, intf.nack, intf.timeout, intf.gnt0});
      end
      intf.req0 = 0;
      tick();
      tests_run++;
      if ({intf.done, intf.gnt0, intf.busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL rd_release: got %b expected 000", {intf.done, intf.gnt0, intf.busy});
      end
   endtask

   task automatic test_round_robin();
      int n;
      apply_reset();
      intf.req0 = 1; intf.addr0 = 7'h10; intf.rw0 = 0; intf.len0 = 4'd0;
      intf.req1 = 1; intf.addr1 = 7'h21; intf.rw1 = 0; intf.len1 = 4'd0;
      tick();
      tests_run++;
      if ({intf.gnt0, intf.gnt1} !== 2'b01 || intf.m_data !== 8'h42) begin
         tests_failed++;
         $display("FAIL rr_first: got gnt %b data %h expected gnt 01 data 42", {intf.gnt0, intf.gnt1}, intf.m_data);
      end
      wait_state(S_ADDR);
      pulse_byte(1);
      count_stop(n);
      tests_run++;
      if (intf.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL rr_first_done: got %b expected 1", intf.done);
      end
      intf.req1 = 0;
      tick();
      tests_run++;
      if ({intf.gnt0, intf.gnt1} !== 2'b00 || dbg_state !== S_IDLE) begin
         tests_failed++;
         $display("FAIL rr_idle_gap: got gnt %b state %0d expected gnt 00 state 0", {intf.gnt0, intf.gnt1}, dbg_state);
      end
      tick();
      tests_run++;
      if ({intf.gnt0, intf.gnt1} !== 2'b10 || intf.m_data !== 8'h20) begin
         tests_failed++;
         $display("FAIL rr_second: got gnt %b data %h expected gnt 10 data 20", {intf.gnt0, intf.gnt1}, intf.m_data);
      end
      wait_state(S_ADDR);
      pulse_byte(1);
      count_stop(n);
      tests_run++;
      if (intf.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL rr_second_done: got %b expected 1", intf.done);
      end
      intf.req0 = 0;
      tick();
   endtask

   task automatic test_nack();
      int n;
      intf.req0 = 1; intf.addr0 = 7'h33; intf.rw0 = 0; intf.len0 = 4'd3;
      tick();
      wait_state(S_ADDR);
      pulse_byte(0);
      tests_run++;
      if (dbg_state !== S_STOP || intf.m_stop !== 1'b1) begin
         tests_failed++;
         $display("FAIL nack_to_stop: got state %0d stop %b expected state 4 stop 1", dbg_state, intf.m_stop);
      end
      count_stop(n);
      tests_run++;
      if (n !== 4 || {intf.done, intf.nack, intf.timeout} !== 3'b010) begin
         tests_failed++;
         $display("FAIL nack_status: got stop %0d status %b expected stop 4 status 010",
                  n, {intf.done, intf.nack, intf.timeout});
      end
      intf.req0 = 0;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      intf.req0 = 1; intf.addr0 = 7'h11; intf.rw0 = 1; intf.len0 = 4'd1;
      tick();
      wait_state(S_ADDR);
      n = 0;
      while (dbg_state === S_ADDR && n < 64) begin n++; tick(); end
      tests_run++;
      if (n !== TO || dbg_state !== S_STOP) begin
         tests_failed++;
         $display("FAIL to_addr_cycles: got %0d state %0d expected %0d state 4", n, dbg_state, TO);
      end
      count_stop(n);
      tests_run++;
      if (n !== 4 || {intf.done, intf.nack, intf.timeout} !== 3'b001) begin
         tests_failed++;
         $display("FAIL to_status: got stop %0d status %b expected stop 4 status 001",
                  n, {intf.done, intf.nack, intf.timeout});
      end
      intf.req0 = 0;
      tick();
   endtask

   task automatic test_len0_write();
      int n;
      intf.req0 = 1; intf.addr0 = 7'h5A; intf.rw0 = 0; intf.len0 = 4'd0;
      tick();
      tests_run++;
      if (intf.m_data !== 8'hB4 || dbg_state !== S_START) begin
         tests_failed++;
         $display("FAIL len0_addr_byte: got data %h state %0d expected data b4 state 1", intf.m_data, dbg_state);
      end
      intf.req0 = 0;
      n = 0;
      while (intf.m_start === 1'b1 && n < 16) begin
         n++;
         intf.m_byte_done = (n == 1); intf.m_ack = 0;
         tick();
      end
      intf.m_byte_done = 0;
      tests_run++;
      if (n !== 4 || dbg_state !== S_ADDR) begin
         tests_failed++;
         $display("FAIL len0_start_ignore: got %0d state %0d expected 4 state 2", n, dbg_state);
      end
      pulse_byte(1);
      tests_run++;
      if (dbg_state !== S_STOP) begin
         tests_failed++;
         $display("FAIL len0_skip_data: got state %0d expected 4", dbg_state);
      end
      pulse_byte(0);
      count_stop(n);
      tests_run++;
      if (n !== 3 || {intf.done, intf.nack, intf.timeout} !== 3'b100) begin
         tests_failed++;
         $display("FAIL len0_done: got stop %0d status %b expected stop 3 status 100",
                  n, {intf.done, intf.nack, intf.timeout});
      end
      tick();
      tests_run++;
      if (dbg_state !== S_IDLE || intf.gnt0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL len0_no_regrant: got state %0d gnt0 %b expected state 0 gnt0 0", dbg_state, intf.gnt0);
      end
   endtask

   task automatic test_wd_clear();
      int n;
      intf.req1 = 1; intf.addr1 = 7'h2C; intf.rw1 = 0; intf.len1 = 4'd2;
      tick();
      wait_state(S_ADDR);
      for (int i = 0; i < 3; i++) begin
         repeat (12) tick();
         pulse_byte(1);
      end
      count_stop(n);
      tests_run++;
      if ({intf.done, intf.nack, intf.timeout, intf.gnt1} !== 4'b1001) begin
         tests_failed++;
         $display("FAIL wd_clear_status: got %b expected 1001", {intf.done, intf.nack, intf.timeout, intf.gnt1});
      end
      intf.req1 = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic seen;
      intf.req0 = 1; intf.addr0 = 7'h4A; intf.rw0 = 1; intf.len0 = 4'd3;
      tick();
      wait_state(S_ADDR);
      pulse_byte(1);
      tests_run++;
      if (dbg_state !== S_DATA) begin
         tests_failed++;
         $display("FAIL rst_mid_setup: got state %0d expected 3", dbg_state);
      end
      #2;
      reset = 1;
      #1;
      tests_run++;
      if ({intf.busy, intf.gnt0, intf.gnt1, intf.m_stop, intf.m_start} !== 5'b0 || dbg_state !== S_IDLE) begin
         tests_failed++;
         $display("FAIL rst_mid_async: got %b state %0d expected 00000 state 0",
                  {intf.busy, intf.gnt0, intf.gnt1, intf.m_stop, intf.m_start}, dbg_state);
      end
      intf.req0 = 0;
      seen = intf.done | intf.nack | intf.timeout;
      repeat (3) begin tick(); seen |= intf.done | intf.nack | intf.timeout; end
      reset = 0;
      repeat (6) begin tick(); seen |= intf.done | intf.nack | intf.timeout; end
      tests_run++;
      if (seen !== 1'b0 || intf.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_no_status: got seen %b busy %b expected 0 0", seen, intf.busy);
      end
   endtask

   initial begin
      test_reset();
      test_read_len2();
      test_round_robin();
      test_nack();
      test_timeout();
      test_len0_write();
      test_wd_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/i2c_txn_sched.md
I2C_TXN_SCHED -- requirements
Module: i2c_txn_sched

Interface
REQ-001 SHALL have parameter TO_CYC, default 1023, meaning the watchdog limit in clk cycles spent waiting for any single m_byte_done.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1 each  transaction request, held high until the matching done/nack pulse.
REQ-005 SHALL have ports addr0, addr1  input  7 each  target slave address.
REQ-006 SHALL have ports rw0, rw1  input  1 each  direction: 1 = read, 0 = write.
REQ-007 SHALL have ports len0, len1  input  4 each  number of data bytes after the address byte; 0 means address-only.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  one-hot grant, high for the whole owned transaction.
REQ-009 SHALL have port m_start  output  1  start command to the I2C master.
REQ-010 SHALL have port m_stop  output  1  stop command to the I2C master.
REQ-011 SHALL have port m_data  output  8  address byte {addr, rw} presented to the master data bus.
REQ-012 SHALL have port m_data_en  output  1  drive enable for m_data; when low, the top level tri-states the bus.
REQ-013 SHALL have port m_byte_done  input  1  one-cycle pulse from the master at the end of each byte plus ACK slot.
REQ-014 SHALL have port m_ack  input  1  ACK value valid with m_byte_done: 1 = ACK, 0 = NACK.
REQ-015 SHALL have ports done, nack, timeout  output  1 each  one-cycle completion, NACK-abort and watchdog-abort status pulses.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, START, ADDR, DATA, STOP and FIN.
REQ-018 IDLE: when any reqN is high, SHALL grant, latch addr/rw/len of the winner and enter START on the next edge.
REQ-019 SHALL arbitrate round-robin: a last-served pointer (reset 0) selects the other requester on a tie; with a single request, that request wins.
REQ-020 START: SHALL assert m_start, m_data_en and m_data = {addr, rw} for exactly 4 cycles, then enter ADDR.
REQ-021 ADDR: SHALL hold m_data_en and m_data until m_byte_done.
REQ-022 ADDR: on m_byte_done with m_ack = 1, SHALL enter DATA if len != 0, else STOP.
REQ-023 ADDR/DATA: on m_byte_done with m_ack = 0, SHALL set the abort flag and enter STOP.
REQ-024 DATA: SHALL decrement a 4-bit byte counter on each m_byte_done and enter STOP when it reaches 0; m_data_en SHALL be low throughout DATA.
REQ-025 DATA: m_ack SHALL be ignored on the final byte when rw = 1 (master NACKs the last read byte).
REQ-026 Watchdog: SHALL count cycles in ADDR/DATA, clear the count on each m_byte_done, and on reaching TO_CYC set the timeout flag and enter STOP.
REQ-027 STOP: SHALL assert m_stop for 4 cycles, then enter FIN.
REQ-028 FIN: SHALL pulse exactly one of done, nack or timeout for 1 cycle, deassert the grant, update the pointer and return to IDLE.
REQ-029 Priority SHALL be timeout over nack over done.
REQ-030 A granted requester dropping reqN mid-transaction SHALL NOT abort the transaction; the transaction runs to FIN.
REQ-031 m_byte_done in IDLE, START, STOP or FIN SHALL be ignored.
REQ-032 In FIN, a new request SHALL NOT be granted until the IDLE cycle that follows, giving at least 1 idle cycle between transactions.

Reset
REQ-033 On reset high, SHALL asynchronously force IDLE.
REQ-034 On reset high, SHALL clear all outputs, the round-robin pointer, the byte counter, the watchdog and the flags to 0.
REQ-035 Reset asserted mid-transaction SHALL drop grants and m_start/m_stop immediately, with no status pulse.

Verification
REQ-036 req0 only, addr0=7'h4A, rw0=1, len0=2, ACK on all bytes -> m_data=8'h95 during START/ADDR, 3 m_byte_done, 4-cycle m_stop, done pulse, gnt0 drops.
REQ-037 req0 and req1 rise together after reset -> gnt1 first (pointer 0); req0 still high -> gnt0 on the next transaction.
REQ-038 Address byte NACKed (m_ack=0) -> no DATA state, m_stop asserted, nack pulse, done stays 0.
REQ-039 TO_CYC=16, no m_byte_done after START -> timeout pulse after 16 ADDR cycles followed by STOP/FIN.
REQ-040 len=0 write with ACK -> START, ADDR, STOP, done; exactly 1 m_byte_done consumed.
REQ-041 reset pulsed during DATA -> busy, gnt and m_stop go 0 asynchronously; done, nack and timeout never pulse.
